// File: rtl/opt_bist_pkg.sv
// rtl/opt_bist_pkg.sv - shared types, widths, taps and next-state functions for opt_bist
package opt_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int MISR_W = 16;
   localparam int STIM_W = 6;
   localparam int RESP_W = 5;

   // Fibonacci LFSR x^6+x^5+1: feedback from bits 5 and 4
   localparam logic [STIM_W-1:0] LFSR_TAPS = 6'h30;
   // MISR feedback from bits 15, 14, 12 and 3
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

   function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] p);
      return {p[STIM_W-2:0], ^(p & LFSR_TAPS)};
   endfunction

   function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [RESP_W-1:0] d);
      return {s[MISR_W-2:0], ^(s & MISR_TAPS)} ^ {{(MISR_W-RESP_W){1'b0}}, d};
   endfunction

endpackage

// File: rtl/opt_bist_misr.sv
// rtl/opt_bist_misr.sv - 16-bit multiple-input signature register with clear and enable
module opt_bist_misr
   import opt_bist_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [RESP_W-1:0] data_i,
   output logic [MISR_W-1:0] sig_o
);

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] sig_d;

   // Next signature: a clear for a new run wins over any capture
   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = misr_next(sig_q, data_i);
      end
   end

   // Signature register, wiped by reset so an aborted run leaves nothing behind
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/opt_bist.sv
// rtl/opt_bist.sv - BIST driver: stimulus generator, response alignment and MISR signature check
module opt_bist
   import opt_bist_pkg::*;
#(
   parameter int unsigned       NUM_PATTERNS = 64,
   parameter int unsigned       RESP_LAT     = 1,
   parameter int unsigned       MODE         = 0,
   parameter logic [STIM_W-1:0] SEED         = 6'h01,
   parameter logic [MISR_W-1:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [RESP_W-1:0] resp_i,
   output logic [STIM_W-1:0] stim_o,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature
);

   localparam logic [15:0]       NP16      = 16'(NUM_PATTERNS);
   localparam logic [15:0]       LAT16     = 16'(RESP_LAT);
   localparam logic [STIM_W-1:0] FIRST_PAT = (MODE == 1) ? SEED : '0;

   state_t            state_q;
   logic [STIM_W-1:0] stim_q;
   logic [15:0]       cnt_q;
   logic              busy_q;
   logic              done_q;

   logic              run;
   logic              smp_vld;
   logic              misr_clr;
   logic [STIM_W-1:0] next_pat;
   logic [MISR_W-1:0] sig;

   assign run      = (state_q == RUN);
   assign misr_clr = start && ((state_q == IDLE) || (state_q == DONE));
   assign next_pat = (MODE == 1) ? lfsr_next(stim_q) : stim_q + 6'd1;

   // Run sequencer; cnt_q counts issued patterns in RUN and elapsed cycles in DRAIN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         stim_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= RUN;
                  stim_q  <= FIRST_PAT;
                  cnt_q   <= 16'd1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               if (cnt_q == NP16) begin
                  stim_q <= '0;
                  if (RESP_LAT > 0) begin
                     state_q <= DRAIN;
                     cnt_q   <= 16'd1;
                  end else begin
                     state_q <= DONE;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  stim_q <= next_pat;
                  cnt_q  <= cnt_q + 16'd1;
               end
            end
            DRAIN: begin
               if (cnt_q == LAT16) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   generate
      if (RESP_LAT == 0) begin : g_no_lat
         assign smp_vld = run;
      end else begin : g_lat
         logic [RESP_LAT-1:0] vld_q;

         // Delay line tagging each issued pattern until its response arrives
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               vld_q <= '0;
            end else begin
               vld_q <= (vld_q << 1) | RESP_LAT'(run);
            end
         end

         assign smp_vld = vld_q[RESP_LAT-1];
      end
   endgenerate

   opt_bist_misr u_misr (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (misr_clr),
      .en_i   (smp_vld),
      .data_i (resp_i),
      .sig_o  (sig)
   );

   assign stim_o    = stim_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign signature = sig;
   assign pass      = done_q && (sig == GOLDEN_SIG);

endmodule

// File: tb/tb_opt_bist.sv
// tb/tb_opt_bist.sv - scoreboard bench for opt_bist across four parameter sets
module tb_opt_bist;
   import opt_bist_pkg::*;

   localparam int ND = 4;

   typedef struct {
      logic [5:0]  stim;
      logic [15:0] sig;
   } cyc_t;

   typedef struct {
      int          cyc;
      logic [15:0] sig;
      logic        pass;
   } res_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start [ND];
   logic [4:0]  resp  [ND];
   logic [5:0]  stim  [ND];
   logic        busy  [ND];
   logic        done  [ND];
   logic        pass  [ND];
   logic [15:0] sig   [ND];

   cyc_t q_cyc [ND][$];
   res_t q_res [ND][$];
   logic done_prev [ND] = '{default: 1'b0};

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [5:0] lfsr_hand [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   opt_bist #(.NUM_PATTERNS(64), .RESP_LAT(1), .MODE(0), .SEED(6'h01), .GOLDEN_SIG(16'h0000)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .resp_i(resp[0]), .stim_o(stim[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig[0]));
   opt_bist #(.NUM_PATTERNS(2), .RESP_LAT(0), .MODE(0), .SEED(6'h01), .GOLDEN_SIG(16'h0002)) u1 (
      .clk(clk), .reset(reset), .start(start[1]), .resp_i(resp[1]), .stim_o(stim[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig[1]));
   opt_bist #(.NUM_PATTERNS(2), .RESP_LAT(0), .MODE(0), .SEED(6'h01), .GOLDEN_SIG(16'h0000)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .resp_i(resp[2]), .stim_o(stim[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig[2]));
   opt_bist #(.NUM_PATTERNS(64), .RESP_LAT(2), .MODE(1), .SEED(6'h01), .GOLDEN_SIG(16'h0000)) u3 (
      .clk(clk), .reset(reset), .start(start[3]), .resp_i(resp[3]), .stim_o(stim[3]),
      .busy(busy[3]), .done(done[3]), .pass(pass[3]), .signature(sig[3]));

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
      end
   endtask

   // Expected per-busy-cycle stim/signature and final result of one run started at edge k
   task automatic push_run(input int d, input int k, input int n, input int l, input bit mode,
                           input logic [5:0] seed, input logic [4:0] r0, input logic [4:0] rr,
                           input logic [15:0] golden);
      logic [15:0] s;
      logic [15:0] sigs[$];
      logic [5:0]  p;
      cyc_t        e;
      res_t        r;
      int          ns;
      s = '0;
      sigs.push_back(s);
      for (int t = 0; t < n; t++) begin
         s = misr_next(s, (t == 0) ? r0 : rr);
         sigs.push_back(s);
      end
      p = mode ? seed : 6'h00;
      for (int j = 0; j < n + l; j++) begin
         ns     = (j < l) ? 0 : j - l;
         e.stim = (j < n) ? p : 6'h00;
         e.sig  = sigs[ns];
         q_cyc[d].push_back(e);
         if (j < n) p = mode ? {p[4:0], p[5] ^ p[4]} : p + 6'd1;
      end
      r.cyc  = k + n + l;
      r.sig  = s;
      r.pass = (s == golden);
      q_res[d].push_back(r);
   endtask

   task automatic wait_done(input int d, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (done[d]) return;
      end
      chk("done_timeout", d, 32'd0, 32'd1);
   endtask

   // Monitor: compare every busy cycle and every done rise against the scoreboard
   always @(negedge clk) begin : mon
      cyc_t e;
      res_t r;
      for (int d = 0; d < ND; d++) begin
         if (busy[d]) begin
            if (q_cyc[d].size() == 0) begin
               chk("busy_unexpected", d, 32'd1, 32'd0);
            end else begin
               e = q_cyc[d].pop_front();
               chk("stim", d, 32'(stim[d]), 32'(e.stim));
               chk("sig_run", d, 32'(sig[d]), 32'(e.sig));
            end
            chk("done_while_busy", d, 32'(done[d]), 32'd0);
         end
         if (done[d] && !done_prev[d]) begin
            if (q_res[d].size() == 0) begin
               chk("done_unexpected", d, 32'd1, 32'd0);
            end else begin
               r = q_res[d].pop_front();
               chk("done_cycle", d, 32'(cyc), 32'(r.cyc));
               chk("sig_final", d, 32'(sig[d]), 32'(r.sig));
               chk("pass", d, 32'(pass[d]), 32'(r.pass));
            end
         end
         done_prev[d] <= done[d];
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int k;
      for (int d = 0; d < ND; d++) begin
         start[d] = 1'b0;
         resp[d]  = 5'h00;
      end
      resp[3] = 5'h15;

      // Reset then idle
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            chk("idle_stim", d, 32'(stim[d]), 32'd0);
            chk("idle_busy", d, 32'(busy[d]), 32'd0);
            chk("idle_done", d, 32'(done[d]), 32'd0);
            chk("idle_sig", d, 32'(sig[d]), 32'd0);
         end
      end

      // Zero response, 64 patterns, latency 1
      @(negedge clk);
      k = cyc + 1;
      start[0] = 1'b1;
      push_run(0, k, 64, 1, 1'b0, 6'h01, 5'h00, 5'h00, 16'h0000);
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 200);
      chk("s2_done_cyc", 0, 32'(cyc), 32'(k + 65));
      chk("s2_sig", 0, 32'(sig[0]), 32'h0000);
      chk("s2_pass", 0, 32'(pass[0]), 32'd1);

      // MISR arithmetic: responses 01 then 00, golden 0002 vs 0000
      @(negedge clk);
      k = cyc + 1;
      start[1] = 1'b1;
      start[2] = 1'b1;
      resp[1]  = 5'h01;
      resp[2]  = 5'h01;
      push_run(1, k, 2, 0, 1'b0, 6'h01, 5'h01, 5'h00, 16'h0002);
      push_run(2, k, 2, 0, 1'b0, 6'h01, 5'h01, 5'h00, 16'h0000);
      @(negedge clk);
      start[1] = 1'b0;
      start[2] = 1'b0;
      @(negedge clk);
      chk("s3_sig_first", 1, 32'(sig[1]), 32'h0001);
      resp[1] = 5'h00;
      resp[2] = 5'h00;
      wait_done(1, 20);
      chk("s3_sig", 1, 32'(sig[1]), 32'h0002);
      chk("s3_pass_gold2", 1, 32'(pass[1]), 32'd1);
      chk("s3_pass_gold0", 2, 32'(pass[2]), 32'd0);

      // LFSR sequence from seed 01
      @(negedge clk);
      k = cyc + 1;
      start[3] = 1'b1;
      push_run(3, k, 64, 2, 1'b1, 6'h01, 5'h15, 5'h15, 16'h0000);
      @(negedge clk);
      start[3] = 1'b0;
      for (int j = 0; j < 64; j++) begin
         if (j < 6) chk("s4_lfsr_hand", 3, 32'(stim[3]), 32'(lfsr_hand[j]));
         if (j == 63) chk("s4_lfsr_wrap", 3, 32'(stim[3]), 32'h01);
         @(negedge clk);
      end
      wait_done(3, 20);

      // start held high through RUN, then restart from DONE
      @(negedge clk);
      k = cyc + 1;
      start[0] = 1'b1;
      push_run(0, k, 64, 1, 1'b0, 6'h01, 5'h00, 5'h00, 16'h0000);
      repeat (65) @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 20);
      chk("s5_held_sig", 0, 32'(sig[0]), 32'h0000);
      k = cyc + 1;
      start[0] = 1'b1;
      push_run(0, k, 64, 1, 1'b0, 6'h01, 5'h00, 5'h00, 16'h0000);
      @(negedge clk);
      start[0] = 1'b0;
      chk("s5_restart_done", 0, 32'(done[0]), 32'd0);
      chk("s5_restart_busy", 0, 32'(busy[0]), 32'd1);
      wait_done(0, 200);

      // Reset mid-run at pattern 10, then a clean rerun
      @(negedge clk);
      k = cyc + 1;
      start[0] = 1'b1;
      push_run(0, k, 64, 1, 1'b0, 6'h01, 5'h00, 5'h00, 16'h0000);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (10) @(negedge clk);
      chk("s6_pat10", 0, 32'(stim[0]), 32'd10);
      #2 reset = 1'b0;
      #1;
      chk("s6_rst_stim", 0, 32'(stim[0]), 32'd0);
      chk("s6_rst_busy", 0, 32'(busy[0]), 32'd0);
      chk("s6_rst_done", 0, 32'(done[0]), 32'd0);
      chk("s6_rst_pass", 0, 32'(pass[0]), 32'd0);
      chk("s6_rst_sig", 0, 32'(sig[0]), 32'd0);
      for (int d = 0; d < ND; d++) begin
         q_cyc[d].delete();
         q_res[d].delete();
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      k = cyc + 1;
      start[0] = 1'b1;
      push_run(0, k, 64, 1, 1'b0, 6'h01, 5'h00, 5'h00, 16'h0000);
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 200);
      chk("s6_done_cyc", 0, 32'(cyc), 32'(k + 65));
      chk("s6_sig", 0, 32'(sig[0]), 32'h0000);
      chk("s6_pass", 0, 32'(pass[0]), 32'd1);

      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("q_cyc_empty", d, 32'(q_cyc[d].size()), 32'd0);
         chk("q_res_empty", d, 32'(q_res[d].size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/opt_bist.md
Name: opt_bist

Overview:
- Built-in self-test driver for the 6-bit-in / 5-bit-out optimisation-test connector interface. Sits on the opposite end of that interface.
- Generates the 6-bit stimulus bus and consumes the 5-bit response bus.
- Compresses the responses into a 16-bit MISR signature and compares it against a golden value, so synthesised netlists can be checked on silicon or in gate-level sim without a reference model.

Parameters:
- NUM_PATTERNS, 64: patterns issued per run. Range 1..65535.
- RESP_LAT, 1: clock cycles from stim_o change to the matching resp_i. Range 0..7.
- MODE, 0: 0 = exhaustive up-counter; 1 = 6-bit LFSR.
- SEED, 6'h01: LFSR start value. Nonzero; ignored in MODE 0.
- GOLDEN_SIG, 16'h0000: expected final signature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; one-cycle pulse or level.
- resp_i  in  5  response bus from the device under test.
- stim_o  out  6  stimulus bus, registered.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid only while done=1: signature == GOLDEN_SIG.
- signature  out  16  current MISR contents.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - stim_o=0, busy=0, done=0, pass=0, signature=0.
  - Pattern counter and valid pipeline cleared.
  - A reset asserted mid-run aborts the run immediately; no partial result is kept.
- FSM transitions:
  - IDLE: start=1 at edge k -> RUN. MISR cleared to 0. Pattern index = 0.
  - RUN: cycle k+1+i drives pattern i on stim_o, for i = 0..NUM_PATTERNS-1. After the last pattern -> DRAIN if RESP_LAT>0, else -> DONE.
  - DRAIN: RESP_LAT cycles. stim_o returns to 0. Outstanding responses are still captured. Then -> DONE.
  - DONE: done=1, busy=0. pass = (signature == GOLDEN_SIG). Signature is frozen. start=1 -> RUN (MISR cleared, same as from IDLE).
- start is ignored while busy=1.
- stim_o = 0 in IDLE, DRAIN and DONE.
- Patterns:
  - MODE 0: pattern i = i[5:0]. Wraps modulo 64 when NUM_PATTERNS > 64.
  - MODE 1: Fibonacci LFSR, x^6+x^5+1. Pattern 0 = SEED; next = {p[4:0], p[5]^p[4]}. Period 63, never zero.
- Response alignment:
  - A RESP_LAT-deep valid shift register tags each issued pattern.
  - resp_i is sampled into the MISR only in cycles where the delayed valid is 1.
  - RESP_LAT=0: resp_i is sampled in the same cycle the pattern is on stim_o.
  - Exactly NUM_PATTERNS samples per run.
- MISR update on a valid sample:
  - fb = s[15]^s[14]^s[12]^s[3].
  - s_next = {s[14:0], fb} ^ {11'b0, resp_i}.
  - Unsigned arithmetic; no other width extension.
- Timing: done first high in cycle k+NUM_PATTERNS+RESP_LAT+1. Total busy cycles = NUM_PATTERNS+RESP_LAT.
- X on resp_i during a valid sample is a bench error. The block does not mask it.

Decomposition:
- Package opt_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - MISR_W=16, STIM_W=6, RESP_W=5;
  - LFSR and MISR tap constants;
  - pure functions lfsr_next() and misr_next(), shared with the bench scoreboard.
- One sub-module, opt_bist_misr: 16-bit MISR with clear, enable, data and signature ports.
- FSM, pattern generator and valid pipeline stay in the top module.

Test Plan:
1. Reset then idle: reset=0 for 3 cycles, release, no start -> stim_o=0, busy=0, done=0, signature=16'h0000 for 20 cycles.
2. Zero response: NUM_PATTERNS=64, RESP_LAT=1, GOLDEN_SIG=0, resp_i tied 0, start pulse at edge k:
   - stim_o steps 0..63 over cycles k+1..k+64;
   - done rises at k+66, signature=0, pass=1.
3. MISR arithmetic: NUM_PATTERNS=2, RESP_LAT=0, resp_i=5'h01 then 5'h00:
   - signature 16'h0001 after the first sample, 16'h0002 after the second;
   - pass=0 with GOLDEN_SIG=0; pass=1 with GOLDEN_SIG=16'h0002.
4. LFSR sequence: MODE=1, SEED=6'h01 -> stim_o = 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, ...; returns to 6'h01 after 63 patterns.
5. Start while busy / restart: start held high throughout RUN -> no restart and the signature is unchanged versus a single pulse. start in DONE -> done drops next cycle and signature clears to 0.
6. Reset mid-run: assert reset at pattern 10 -> all outputs 0 asynchronously. After release plus start, the full run reproduces the scenario-2 result exactly.
